udp_packer: RTL and testbench

- Transmit-side counterpart of the UDP receive filter: takes a raw payload AXI-Stream plus a per-frame length descriptor and emits a complete Ethernet II / IPv4 / UDP frame on a 32-bit AXI-Stream toward the MAC TX path.
- Builds the 42-byte header from parameters, a per-frame IP identification counter and the IPv4 header checksum, then shifts the payload by 2 bytes to follow the header.
- Does not append FCS or padding; both are the downstream MAC's job.

---
 rtl/udp_packer.sv | 242 ++++++++++++++++++++++++
 tb/tb_udp_packer.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_packer.sv
// UDP/IPv4/Ethernet II frame builder: prepends a 42-byte header to a 32-bit payload
// stream and realigns the payload by two bytes behind it.
module udp_packer #(
   parameter int unsigned STREAM_DATA_WIDTH = 32,
   parameter logic [47:0] SRC_MAC           = 48'h000a35000102,
   parameter logic [47:0] DST_MAC           = 48'hffffffffffff,
   parameter logic [31:0] SRC_IP            = 32'hc0a8120a,
   parameter logic [31:0] DST_IP            = 32'hc0a81201,
   parameter logic [15:0] SRC_PORT          = 16'h1f90,
   parameter logic [15:0] DST_PORT          = 16'h1f90,
   parameter logic [7:0]  IP_TTL            = 8'd64,
   parameter int unsigned PAYLOAD_MAX_SIZE  = 1472,
   localparam int unsigned LEN_WIDTH        = $clog2(PAYLOAD_MAX_SIZE + 1)
) (
   input  logic                           clk_i,
   input  logic                           s_rst_i,
   input  logic                           hdr_valid_i,
   output logic                           hdr_ready_o,
   input  logic [LEN_WIDTH-1:0]           payload_len_i,
   input  logic [STREAM_DATA_WIDTH-1:0]   s_axis_tdata_i,
   input  logic [STREAM_DATA_WIDTH/8-1:0] s_axis_tkeep_i,
   input  logic                           s_axis_tvalid_i,
   input  logic                           s_axis_tlast_i,
   output logic                           s_axis_tready_o,
   output logic [STREAM_DATA_WIDTH-1:0]   m_axis_tdata_o,
   output logic [STREAM_DATA_WIDTH/8-1:0] m_axis_tkeep_o,
   output logic                           m_axis_tvalid_o,
   output logic                           m_axis_tlast_o,
   input  logic                           m_axis_tready_i,
   output logic                           len_err_o,
   output logic                           frame_done_o,
   output logic [2:0]                     dbg_state_o,
   output logic [15:0]                    dbg_ip_id_o
);

   // Handshakes: a transfer happens on a rising edge where valid && ready; a
   // source never drops valid or changes data before its transfer completes.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CALC    = 3'd1,
      ST_HDR     = 3'd2,
      ST_MERGE   = 3'd3,
      ST_PAYLOAD = 3'd4,
      ST_TAIL    = 3'd5,
      ST_LAST    = 3'd6
   } state_e;

   state_e                 state_q, state_d;
   logic                   hdr_ready_q, hdr_ready_d;
   logic [LEN_WIDTH-1:0]   len_q, len_d;
   logic [15:0]            id_q, id_d;
   logic [15:0]            ip_id_q, ip_id_d;
   logic [15:0]            csum_q, csum_d;
   logic [3:0]             beat_q, beat_d;
   logic [15:0]            carry_q, carry_d;
   logic [1:0]             keep_hi_q, keep_hi_d;
   logic [15:0]            byte_cnt_q, byte_cnt_d;
   logic [31:0]            m_data_q, m_data_d;
   logic [3:0]             m_keep_q, m_keep_d;
   logic                   m_valid_q, m_valid_d;
   logic                   m_last_q, m_last_d;

   logic                   out_ld;
   logic                   s_ready;
   logic                   len_err;
   logic [15:0]            tot_len, udp_len;
   logic [19:0]            csum_sum;
   logic [16:0]            csum_f1;
   logic [15:0]            csum_f2;
   logic [319:0]           hdr_be;
   logic [31:0]            hdr_be_word;
   logic [31:0]            hdr_word;
   logic [15:0]            lo16;
   logic [15:0]            n_bytes;
   logic [15:0]            cnt_sum;

   assign tot_len = 16'(len_q) + 16'd28;
   assign udp_len = 16'(len_q) + 16'd8;

   // Header bytes 0..39 in wire order, byte 0 in the top bits; bytes 40-41 (UDP
   // checksum, disabled) are the zero low half of the first payload beat.
   assign hdr_be = {DST_MAC, SRC_MAC, 16'h0800, 16'h4500, tot_len, id_q, 16'h4000,
                    IP_TTL, 8'h11, csum_q, SRC_IP, DST_IP, SRC_PORT, DST_PORT, udp_len};

   always_comb begin
      csum_sum = 20'h04500 + 20'(tot_len) + 20'(id_q) + 20'h04000 + 20'({IP_TTL, 8'h11})
               + 20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0]) + 20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);
      csum_f1  = {1'b0, csum_sum[15:0]} + 17'(csum_sum[19:16]);
      csum_f2  = csum_f1[15:0] + 16'(csum_f1[16]);
   end

   always_comb begin
      hdr_be_word = 32'h0;
      for (int i = 0; i < 10; i++) begin
         if (beat_q == 4'(i)) hdr_be_word = hdr_be[319-32*i -: 32];
      end
      hdr_word = {hdr_be_word[7:0], hdr_be_word[15:8], hdr_be_word[23:16], hdr_be_word[31:24]};
   end

   always_comb begin
      case (s_axis_tkeep_i)
         4'b0001: n_bytes = 16'd1;
         4'b0011: n_bytes = 16'd2;
         4'b0111: n_bytes = 16'd3;
         default: n_bytes = 16'd4;
      endcase
      cnt_sum = byte_cnt_q + n_bytes;
      lo16    = (state_q == ST_MERGE) ? 16'h0000 : carry_q;
   end

   assign out_ld = !m_valid_q || m_axis_tready_i;

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      id_d       = id_q;
      ip_id_d    = ip_id_q;
      csum_d     = csum_q;
      beat_d     = beat_q;
      carry_d    = carry_q;
      keep_hi_d  = keep_hi_q;
      byte_cnt_d = byte_cnt_q;
      m_data_d   = m_data_q;
      m_keep_d   = m_keep_q;
      m_last_d   = m_last_q;
      m_valid_d  = m_valid_q && !m_axis_tready_i;
      s_ready    = 1'b0;
      len_err    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (hdr_ready_q && hdr_valid_i) begin
               len_d      = payload_len_i;
               id_d       = ip_id_q;
               byte_cnt_d = 16'h0;
               state_d    = ST_CALC;
            end
         end
         ST_CALC: begin
            csum_d  = ~csum_f2;
            beat_d  = 4'd0;
            state_d = ST_HDR;
         end
         ST_HDR: begin
            if (out_ld) begin
               m_data_d  = hdr_word;
               m_keep_d  = 4'hf;
               m_last_d  = 1'b0;
               m_valid_d = 1'b1;
               beat_d    = beat_q + 4'd1;
               if (beat_q == 4'd9) state_d = ST_MERGE;
            end
         end
         ST_MERGE, ST_PAYLOAD: begin
            s_ready = out_ld;
            if (s_axis_tvalid_i && out_ld) begin
               m_data_d   = {s_axis_tdata_i[15:0], lo16};
               m_keep_d   = 4'hf;
               m_last_d   = 1'b0;
               m_valid_d  = 1'b1;
               carry_d    = s_axis_tdata_i[31:16];
               byte_cnt_d = cnt_sum;
               state_d    = ST_PAYLOAD;
               if (s_axis_tlast_i) begin
                  len_err = (cnt_sum != 16'(len_q));
                  // Up to two bytes on the last beat fit beside the carried pair.
                  if (s_axis_tkeep_i <= 4'b0011) begin
                     m_keep_d = {s_axis_tkeep_i[1:0], 2'b11};
                     m_last_d = 1'b1;
                     state_d  = ST_LAST;
                  end else begin
                     keep_hi_d = s_axis_tkeep_i[3:2];
                     state_d   = ST_TAIL;
                  end
               end
            end
         end
         ST_TAIL: begin
            if (out_ld) begin
               m_data_d  = {16'h0000, carry_q};
               m_keep_d  = {2'b00, keep_hi_q};
               m_last_d  = 1'b1;
               m_valid_d = 1'b1;
               state_d   = ST_LAST;
            end
         end
         ST_LAST: begin
            if (m_valid_q && m_axis_tready_i) begin
               ip_id_d = ip_id_q + 16'd1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      hdr_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (s_rst_i) begin
         state_q    <= ST_IDLE;
         hdr_ready_q <= 1'b0;
         len_q      <= '0;
         id_q       <= 16'h0;
         ip_id_q    <= 16'h0;
         csum_q     <= 16'h0;
         beat_q     <= 4'd0;
         carry_q    <= 16'h0;
         keep_hi_q  <= 2'b00;
         byte_cnt_q <= 16'h0;
         m_data_q   <= 32'h0;
         m_keep_q   <= 4'h0;
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         hdr_ready_q <= hdr_ready_d;
         len_q      <= len_d;
         id_q       <= id_d;
         ip_id_q    <= ip_id_d;
         csum_q     <= csum_d;
         beat_q     <= beat_d;
         carry_q    <= carry_d;
         keep_hi_q  <= keep_hi_d;
         byte_cnt_q <= byte_cnt_d;
         m_data_q   <= m_data_d;
         m_keep_q   <= m_keep_d;
         m_valid_q  <= m_valid_d;
         m_last_q   <= m_last_d;
      end
   end

   assign hdr_ready_o     = hdr_ready_q;
   assign s_axis_tready_o = s_ready && !s_rst_i;
   assign len_err_o       = len_err && !s_rst_i;
   assign m_axis_tdata_o  = m_data_q;
   assign m_axis_tkeep_o  = m_keep_q;
   assign m_axis_tvalid_o = m_valid_q;
   assign m_axis_tlast_o  = m_last_q;
   assign frame_done_o    = m_valid_q && m_last_q && m_axis_tready_i;
   assign dbg_state_o     = state_q;
   assign dbg_ip_id_o     = ip_id_q;

endmodule

// File: tb/tb_udp_packer.sv
// Directed bench for udp_packer: drives descriptors and payload, collects the output
// frame and checks it against hand values and a byte-level frame model.
module tb_udp_packer;

   localparam logic [47:0] SRC_MAC  = 48'h000a35000102;
   localparam logic [47:0] DST_MAC  = 48'hffffffffffff;
   localparam logic [31:0] SRC_IP   = 32'hc0a8120a;
   localparam logic [31:0] DST_IP   = 32'hc0a81201;
   localparam logic [15:0] SRC_PORT = 16'h1f90;
   localparam logic [15:0] DST_PORT = 16'h1f90;
   localparam logic [7:0]  IP_TTL   = 8'd64;
   localparam logic [2:0]  S_IDLE   = 3'd0;
   localparam logic [2:0]  S_PAY    = 3'd4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        hdr_valid = 1'b0;
   logic        hdr_ready;
   logic [10:0] payload_len = '0;
   logic [31:0] s_tdata = '0;
   logic [3:0]  s_tkeep = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tlast = 1'b0;
   logic        s_tready;
   logic [31:0] m_tdata;
   logic [3:0]  m_tkeep;
   logic        m_tvalid;
   logic        m_tlast;
   logic        m_tready = 1'b0;
   logic        len_err;
   logic        frame_done;
   logic [2:0]  dbg_state;
   logic [15:0] dbg_ip_id;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]  pay[$];
   logic [36:0] got_q[$];
   logic [36:0] exp_q[$];
   logic [15:0] exp_id;
   int done_pulses, err_pulses, err_at_last, stall_bad, first_lat;
   bit timed_out;

   always #5 clk = ~clk;

   udp_packer dut (
      .clk_i(clk), .s_rst_i(rst),
      .hdr_valid_i(hdr_valid), .hdr_ready_o(hdr_ready), .payload_len_i(payload_len),
      .s_axis_tdata_i(s_tdata), .s_axis_tkeep_i(s_tkeep), .s_axis_tvalid_i(s_tvalid),
      .s_axis_tlast_i(s_tlast), .s_axis_tready_o(s_tready),
      .m_axis_tdata_o(m_tdata), .m_axis_tkeep_o(m_tkeep), .m_axis_tvalid_o(m_tvalid),
      .m_axis_tlast_o(m_tlast), .m_axis_tready_i(m_tready),
      .len_err_o(len_err), .frame_done_o(frame_done),
      .dbg_state_o(dbg_state), .dbg_ip_id_o(dbg_ip_id)
   );

   // Drive one descriptor plus nbytes of pay[]; collect output beats until tlast or budget.
   task automatic run_frame(input int len_desc, input int nbytes, input int rdy_pct,
                            input int vld_pct, input int budget);
      int sent, cyc, hs_cyc, rem, beat_n;
      bit hdr_done, fin, pending, stalled;
      logic [36:0] held, cur;
      got_q.delete();
      done_pulses = 0; err_pulses = 0; err_at_last = 0; stall_bad = 0; first_lat = -1;
      sent = 0; cyc = 0; hs_cyc = 0; beat_n = 0;
      hdr_done = 0; fin = 0; pending = 0; stalled = 0; held = '0;
      while (!fin && cyc < budget) begin
         @(negedge clk);
         cyc++;
         hdr_valid   = !hdr_done;
         payload_len = 11'(len_desc);
         if (!pending && sent < nbytes && $urandom_range(99) < vld_pct) begin
            rem = nbytes - sent;
            beat_n = (rem >= 4) ? 4 : rem;
            s_tdata = '0;
            s_tkeep = '0;
            for (int n = 0; n < 4; n++) begin
               if (n < beat_n) begin
                  s_tdata[8*n +: 8] = pay[sent+n];
                  s_tkeep[n] = 1'b1;
               end
            end
            s_tlast = (rem <= 4);
            pending = 1;
         end
         s_tvalid = pending;
         m_tready = ($urandom_range(99) < rdy_pct);
         #1;
         cur = {m_tlast, m_tkeep, m_tdata};
         if (hdr_valid && hdr_ready) begin
            hdr_done = 1;
            hs_cyc = cyc;
         end
         if (s_tvalid && s_tready) begin
            if (len_err && s_tlast) err_at_last++;
            pending = 0;
            sent += beat_n;
         end
         if (len_err) err_pulses++;
         if (frame_done) done_pulses++;
         if (hdr_done && m_tvalid && first_lat < 0) first_lat = cyc - hs_cyc;
         if (stalled && cur !== held) stall_bad++;
         stalled = m_tvalid && !m_tready;
         held = cur;
         if (m_tvalid && m_tready) begin
            got_q.push_back(cur);
            if (m_tlast) fin = 1;
         end
      end
      timed_out = !fin;
   endtask

   // Byte-level frame model: header fields written out one by one, then payload, then beats.
   task automatic build_expected(input int len_desc, input logic [15:0] id);
      logic [7:0]  b[$];
      logic [15:0] tl, ul, ck;
      logic [31:0] w;
      logic [3:0]  k;
      int sum;
      tl = 16'(len_desc + 28);
      ul = 16'(len_desc + 8);
      for (int i = 5; i >= 0; i--) b.push_back(DST_MAC[8*i +: 8]);
      for (int i = 5; i >= 0; i--) b.push_back(SRC_MAC[8*i +: 8]);
      b.push_back(8'h08); b.push_back(8'h00); b.push_back(8'h45); b.push_back(8'h00);
      b.push_back(tl[15:8]); b.push_back(tl[7:0]); b.push_back(id[15:8]); b.push_back(id[7:0]);
      b.push_back(8'h40); b.push_back(8'h00); b.push_back(IP_TTL); b.push_back(8'h11);
      b.push_back(8'h00); b.push_back(8'h00);
      for (int i = 3; i >= 0; i--) b.push_back(SRC_IP[8*i +: 8]);
      for (int i = 3; i >= 0; i--) b.push_back(DST_IP[8*i +: 8]);
      b.push_back(SRC_PORT[15:8]); b.push_back(SRC_PORT[7:0]);
      b.push_back(DST_PORT[15:8]); b.push_back(DST_PORT[7:0]);
      b.push_back(ul[15:8]); b.push_back(ul[7:0]); b.push_back(8'h00); b.push_back(8'h00);
      sum = 0;
      for (int i = 14; i < 34; i += 2) sum += int'({b[i], b[i+1]});
      while (sum > 32'hffff) sum = (sum & 32'hffff) + (sum >> 16);
      ck = ~sum[15:0];
      b[24] = ck[15:8];
      b[25] = ck[7:0];
      foreach (pay[i]) b.push_back(pay[i]);
      exp_q.delete();
      for (int i = 0; i < b.size(); i += 4) begin
         w = '0;
         k = '0;
         for (int n = 0; n < 4; n++) begin
            if (i + n < b.size()) begin
               w[8*n +: 8] = b[i+n];
               k[n] = 1'b1;
            end
         end
         exp_q.push_back({(i + 4 >= b.size()), k, w});
      end
   endtask

   function automatic int first_diff();
      if (got_q.size() != exp_q.size()) return (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return i;
      return -1;
   endfunction

   function automatic logic [7:0] got_byte(input int i);
      logic [36:0] w;
      if (i / 4 >= got_q.size()) return 8'h00;
      w = got_q[i/4];
      return w[8*(i%4) +: 8];
   endfunction

   function automatic logic [15:0] hdr_fold();
      int sum;
      sum = 0;
      for (int i = 14; i < 34; i += 2) sum += int'({got_byte(i), got_byte(i+1)});
      while (sum > 32'hffff) sum = (sum & 32'hffff) + (sum >> 16);
      return sum[15:0];
   endfunction

   task automatic fill_pattern(input int n, input logic [7:0] base);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(base + 8'(i));
   endtask

   task automatic apply_reset(input int cycles);
      @(negedge clk);
      rst = 1'b1; hdr_valid = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
      exp_id = 16'h0;
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      vectors++;
      if ({hdr_ready, s_tready, m_tvalid, m_tlast, len_err, frame_done} !== 6'b0 ||
          m_tdata !== 32'h0 || m_tkeep !== 4'h0) begin
         miscompares++;
         $display("FAIL %s_outputs got rdy=%b srdy=%b v=%b l=%b err=%b done=%b d=%h k=%h exp all 0",
                  tag, hdr_ready, s_tready, m_tvalid, m_tlast, len_err, frame_done, m_tdata, m_tkeep);
      end
      vectors++;
      if (dbg_state !== S_IDLE || dbg_ip_id !== 16'h0) begin
         miscompares++;
         $display("FAIL %s_state got state=%0d id=%h exp state=0 id=0000", tag, dbg_state, dbg_ip_id);
      end
   endtask

   task automatic test_reset();
      apply_reset(2);
      check_all_zero("reset");
      @(negedge clk);
      #1;
      vectors++;
      if (hdr_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_hdr_ready got %b exp 1", hdr_ready);
      end
   endtask

   task automatic test_single_beat();
      int d;
      fill_pattern(4, 8'ha0);
      build_expected(4, exp_id);
      run_frame(4, 4, 100, 100, 200);
      vectors++;
      if (timed_out !== 1'b0 || got_q.size() !== 12) begin
         miscompares++;
         $display("FAIL single_count got %0d beats timeout=%0d exp 12 beats", got_q.size(), timed_out);
      end
      vectors++;
      if (first_lat !== 3) begin
         miscompares++;
         $display("FAIL single_latency got %0d exp 3", first_lat);
      end
      vectors++;
      if (got_q[3][31:0] !== 32'h00450008) begin
         miscompares++;
         $display("FAIL single_beat3 got %h exp 00450008", got_q[3][31:0]);
      end
      vectors++;
      if (got_q[4][15:0] !== 16'h2000) begin
         miscompares++;
         $display("FAIL single_beat4_len got %h exp 2000", got_q[4][15:0]);
      end
      vectors++;
      if (got_q[6][31:0] !== 32'ha8c07195) begin
         miscompares++;
         $display("FAIL single_beat6_csum got %h exp a8c07195", got_q[6][31:0]);
      end
      vectors++;
      if (got_q[10] !== {1'b0, 4'hf, 32'ha1a00000}) begin
         miscompares++;
         $display("FAIL single_beat10 got %h exp %h", got_q[10], {1'b0, 4'hf, 32'ha1a00000});
      end
      vectors++;
      if (got_q[11] !== {1'b1, 4'h3, 32'h0000a3a2}) begin
         miscompares++;
         $display("FAIL single_beat11 got %h exp %h", got_q[11], {1'b1, 4'h3, 32'h0000a3a2});
      end
      vectors++;
      if (done_pulses !== 1 || err_pulses !== 0) begin
         miscompares++;
         $display("FAIL single_pulses got done=%0d err=%0d exp done=1 err=0", done_pulses, err_pulses);
      end
      d = first_diff();
      vectors++;
      if (d !== -1) begin
         miscompares++;
         $display("FAIL single_model beat %0d got %h exp %h", d, got_q[d], exp_q[d]);
      end
      exp_id++;
   endtask

   task automatic test_two_byte();
      int d;
      fill_pattern(2, 8'ha0);
      build_expected(2, exp_id);
      run_frame(2, 2, 100, 100, 200);
      vectors++;
      if (timed_out !== 1'b0 || got_q.size() !== 11 || got_q[10] !== {1'b1, 4'hf, 32'ha1a00000}) begin
         miscompares++;
         $display("FAIL two_byte_last got %0d beats last=%h exp 11 beats last=%h",
                  got_q.size(), got_q[got_q.size()-1], {1'b1, 4'hf, 32'ha1a00000});
      end
      vectors++;
      if ({got_byte(18), got_byte(19)} !== 16'h0001) begin
         miscompares++;
         $display("FAIL two_byte_id got %h exp 0001", {got_byte(18), got_byte(19)});
      end
      d = first_diff();
      vectors++;
      if (d !== -1 || done_pulses !== 1) begin
         miscompares++;
         $display("FAIL two_byte_model beat %0d got %h exp %h done=%0d", d, got_q[d], exp_q[d], done_pulses);
      end
      exp_id++;
   endtask

   task automatic test_len_err();
      int d;
      fill_pattern(12, 8'h10);
      build_expected(8, exp_id);
      run_frame(8, 12, 100, 100, 200);
      vectors++;
      if (err_pulses !== 1 || err_at_last !== 1) begin
         miscompares++;
         $display("FAIL len_err_pulse got pulses=%0d at_tlast=%0d exp 1 1", err_pulses, err_at_last);
      end
      vectors++;
      if (timed_out !== 1'b0 || got_q.size() !== 14 || got_q[13][35:32] !== 4'h3) begin
         miscompares++;
         $display("FAIL len_err_size got %0d beats exp 14 beats (54 bytes)", got_q.size());
      end
      vectors++;
      if ({got_byte(16), got_byte(17)} !== 16'h0024) begin
         miscompares++;
         $display("FAIL len_err_iplen got %h exp 0024", {got_byte(16), got_byte(17)});
      end
      d = first_diff();
      vectors++;
      if (d !== -1) begin
         miscompares++;
         $display("FAIL len_err_model beat %0d got %h exp %h", d, got_q[d], exp_q[d]);
      end
      exp_id++;
   endtask

   task automatic test_long_random();
      int d;
      pay.delete();
      for (int i = 0; i < 1472; i++) pay.push_back(8'($urandom_range(255)));
      build_expected(1472, exp_id);
      run_frame(1472, 1472, 50, 70, 8000);
      vectors++;
      if (timed_out !== 1'b0 || got_q.size() !== 379) begin
         miscompares++;
         $display("FAIL long_count got %0d beats timeout=%0d exp 379", got_q.size(), timed_out);
      end
      d = first_diff();
      vectors++;
      if (d !== -1) begin
         miscompares++;
         $display("FAIL long_model beat %0d got %h exp %h", d, got_q[d], exp_q[d]);
      end
      vectors++;
      if (stall_bad !== 0) begin
         miscompares++;
         $display("FAIL long_stall_stable got %0d changes exp 0", stall_bad);
      end
      vectors++;
      if (hdr_fold() !== 16'hffff) begin
         miscompares++;
         $display("FAIL long_csum_fold got %h exp ffff", hdr_fold());
      end
      vectors++;
      if ({got_byte(18), got_byte(19)} !== exp_id || done_pulses !== 1) begin
         miscompares++;
         $display("FAIL long_id got %h done=%0d exp %h done=1", {got_byte(18), got_byte(19)}, done_pulses, exp_id);
      end
      exp_id++;
   endtask

   task automatic test_id_wrap();
      int d;
      @(negedge clk);
      hdr_valid = 1'b0; s_tvalid = 1'b0;
      force dut.ip_id_q = 16'hffff;
      repeat (2) @(posedge clk);
      #1;
      release dut.ip_id_q;
      exp_id = 16'hffff;
      fill_pattern(5, 8'h50);
      build_expected(5, exp_id);
      run_frame(5, 5, 100, 100, 200);
      vectors++;
      if ({got_byte(18), got_byte(19)} !== 16'hffff || got_q[got_q.size()-1][35:32] !== 4'h7) begin
         miscompares++;
         $display("FAIL wrap_id_ffff got id=%h lastkeep=%h exp id=ffff lastkeep=7",
                  {got_byte(18), got_byte(19)}, got_q[got_q.size()-1][35:32]);
      end
      d = first_diff();
      vectors++;
      if (d !== -1) begin
         miscompares++;
         $display("FAIL wrap_model_ffff beat %0d got %h exp %h", d, got_q[d], exp_q[d]);
      end
      exp_id++;
      fill_pattern(3, 8'h60);
      build_expected(3, exp_id);
      run_frame(3, 3, 100, 100, 200);
      vectors++;
      if ({got_byte(18), got_byte(19)} !== 16'h0000) begin
         miscompares++;
         $display("FAIL wrap_id_0000 got %h exp 0000", {got_byte(18), got_byte(19)});
      end
      d = first_diff();
      vectors++;
      if (d !== -1 || hdr_fold() !== 16'hffff) begin
         miscompares++;
         $display("FAIL wrap_model_0000 beat %0d got %h exp %h fold=%h", d, got_q[d], exp_q[d], hdr_fold());
      end
      exp_id++;
   endtask

   task automatic test_reset_mid();
      int d;
      fill_pattern(64, 8'h80);
      run_frame(64, 64, 100, 100, 20);
      vectors++;
      if (dbg_state !== S_PAY) begin
         miscompares++;
         $display("FAIL mid_state_before got %0d exp %0d", dbg_state, S_PAY);
      end
      apply_reset(1);
      check_all_zero("mid_reset");
      fill_pattern(4, 8'ha0);
      build_expected(4, exp_id);
      run_frame(4, 4, 100, 100, 200);
      d = first_diff();
      vectors++;
      if (timed_out !== 1'b0 || d !== -1 || done_pulses !== 1) begin
         miscompares++;
         $display("FAIL mid_after_frame beat %0d got %h exp %h done=%0d", d, got_q[d], exp_q[d], done_pulses);
      end
      exp_id++;
   endtask

   initial begin
      exp_id = 16'h0;
      test_reset();
      test_single_beat();
      test_two_byte();
      test_len_err();
      test_long_random();
      test_id_wrap();
      test_reset_mid();
      @(negedge clk);
      hdr_valid = 1'b0;
      s_tvalid = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
